noaa_stats_engine: RTL and testbench



---
 rtl/noaa_pkg.sv | 32 +++
 rtl/noaa_stats_engine_seq_divider.sv | 77 +++++++
 rtl/noaa_stats_engine.sv | 247 ++++++++++++++++++++++++
 tb/tb_noaa_stats_engine.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/noaa_pkg.sv
// Shared definitions for the NOAA statistics engine: defaults, output-select codes,
// the width helper and the sequencing state type.
package noaa_pkg;

   localparam int TEMP_WIDTH_DEF = 12;
   localparam int N_SAMPLES_DEF  = 14;

   localparam logic AVG = 1'b0;
   localparam logic SD  = 1'b1;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   typedef enum logic [2:0] {
      IDLE,
      UPDATE,
      DIV_MEAN,
      DIV_SQ,
      VAR,
      SQRT,
      FIN
   } state_e;

endpackage

// File: rtl/noaa_stats_engine_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle. The first bit is resolved on
// the start edge, so the quotient is valid (done pulses) exactly W cycles after start.
module seq_divider
   import noaa_pkg::*;
#(
   parameter int W = 28
) (
   input  logic         clk,
   input  logic         srst,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient
);

   localparam int CNTW = clog2(W + 1);

   logic [W-1:0]    rem_q, rem_d;
   logic [W-1:0]    quo_q, quo_d;
   logic [W-1:0]    dvs_q, dvs_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            done_q, done_d;

   logic [W-1:0] src_rem;
   logic [W-1:0] src_quo;
   logic [W-1:0] src_dvs;
   logic [W:0]   trial;
   logic         q_bit;

   always_comb begin
      src_rem = start ? '0 : rem_q;
      src_quo = start ? dividend : quo_q;
      src_dvs = start ? divisor : dvs_q;
      trial   = {src_rem, src_quo[W-1]};
      q_bit   = 1'b0;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      if (start || (cnt_q != '0)) begin
         if (trial >= {1'b0, src_dvs}) begin
            rem_d = W'(trial - {1'b0, src_dvs});
            q_bit = 1'b1;
         end else begin
            rem_d = trial[W-1:0];
         end
         quo_d  = {src_quo[W-2:0], q_bit};
         dvs_d  = src_dvs;
         cnt_d  = start ? CNTW'(W - 1) : cnt_q - 1'b1;
         done_d = (cnt_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign busy     = (cnt_q != '0);
   assign done     = done_q;
   assign quotient = quo_q;

endmodule

// File: rtl/noaa_stats_engine.sv
// Self-timed temperature sampler keeping a sliding window of N_SAMPLES readings and
// reporting its floor mean and floor population standard deviation.
module noaa_stats_engine
   import noaa_pkg::*;
#(
   parameter int TEMP_WIDTH    = TEMP_WIDTH_DEF,
   parameter int N_SAMPLES     = N_SAMPLES_DEF,
   parameter int SAMPLE_PERIOD = 128
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  MODE,
   input  logic [TEMP_WIDTH-1:0] TN,
   output logic                  SAMPLE,
   output logic                  DONE,
   output logic                  FULL,
   output logic [TEMP_WIDTH-1:0] AVG_SD
);

   localparam int CW    = clog2(N_SAMPLES + 1);
   localparam int SUM_W = TEMP_WIDTH + CW;
   localparam int SQ_W  = 2 * TEMP_WIDTH + CW;
   localparam int LAT   = 2 * SQ_W + TEMP_WIDTH + 3;
   localparam int PW    = clog2(SAMPLE_PERIOD);
   localparam int PTRW  = clog2(N_SAMPLES);
   localparam int SCW   = clog2(TEMP_WIDTH) + 1;

   generate
      if (SAMPLE_PERIOD <= LAT + 1) begin : g_bad_period
         $error("SAMPLE_PERIOD must exceed LAT+1");
      end
      if ((N_SAMPLES < 2) || (N_SAMPLES > 64)) begin : g_bad_depth
         $error("N_SAMPLES must lie in 2..64");
      end
   endgenerate

   state_e state_q, state_d;

   logic [PW-1:0]           per_q, per_d;
   logic [PTRW-1:0]         wp_q, wp_d;
   logic [CW-1:0]           count_q, count_d;
   logic [SUM_W-1:0]        sum_q, sum_d;
   logic [SQ_W-1:0]         sumsq_q, sumsq_d;
   logic [TEMP_WIDTH-1:0]   tn_q, tn_d;
   logic                    old_ok_q, old_ok_d;
   logic [TEMP_WIDTH-1:0]   mean_q, mean_d;
   logic [SQ_W-1:0]         qsq_q, qsq_d;
   logic [2*TEMP_WIDTH-1:0] rad_q, rad_d;
   logic [TEMP_WIDTH:0]     rem_q, rem_d;
   logic [TEMP_WIDTH-1:0]   root_q, root_d;
   logic [SCW-1:0]          sqc_q, sqc_d;
   logic [TEMP_WIDTH-1:0]   avg_q, avg_d;
   logic [TEMP_WIDTH-1:0]   sd_q, sd_d;

   logic [TEMP_WIDTH-1:0] mem_q [N_SAMPLES];
   logic [TEMP_WIDTH-1:0] rd_q;
   logic                  mem_we;

   logic                  sample_w;
   logic                  full_w;
   logic [TEMP_WIDTH-1:0] old_w;
   logic [SQ_W-1:0]       tn_ext, old_ext, mean_ext;
   logic [TEMP_WIDTH+2:0] rem_sh;
   logic [TEMP_WIDTH+2:0] trial;
   logic [TEMP_WIDTH-1:0] root_n;

   logic            div_start;
   logic [SQ_W-1:0] div_dividend;
   logic [SQ_W-1:0] div_divisor;
   logic            div_busy;
   logic            div_done;
   logic [SQ_W-1:0] div_quo;
   logic            div_fin;

   seq_divider #(
      .W(SQ_W)
   ) u_div (
      .clk     (CLK),
      .srst    (RESET),
      .start   (div_start),
      .dividend(div_dividend),
      .divisor (div_divisor),
      .busy    (div_busy),
      .done    (div_done),
      .quotient(div_quo)
   );

   assign sample_w = (per_q == '0) && !RESET;
   assign full_w   = (count_q == CW'(N_SAMPLES));
   assign div_fin  = div_done && !div_busy;
   // The slot under the pointer only holds a live sample once the window has filled.
   assign old_w    = old_ok_q ? rd_q : '0;
   assign tn_ext   = SQ_W'(tn_q);
   assign old_ext  = SQ_W'(old_w);
   assign mean_ext = SQ_W'(mean_q);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (sample_w) state_d = UPDATE;
         UPDATE:   state_d = DIV_MEAN;
         DIV_MEAN: if (div_fin) state_d = DIV_SQ;
         DIV_SQ:   if (div_fin) state_d = VAR;
         VAR:      state_d = SQRT;
         SQRT:     if (sqc_q == SCW'(TEMP_WIDTH - 1)) state_d = FIN;
         FIN:      state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      per_d        = (per_q == PW'(SAMPLE_PERIOD - 1)) ? '0 : per_q + 1'b1;
      wp_d         = wp_q;
      count_d      = count_q;
      sum_d        = sum_q;
      sumsq_d      = sumsq_q;
      tn_d         = tn_q;
      old_ok_d     = old_ok_q;
      mean_d       = mean_q;
      qsq_d        = qsq_q;
      rad_d        = rad_q;
      rem_d        = rem_q;
      root_d       = root_q;
      sqc_d        = sqc_q;
      avg_d        = avg_q;
      sd_d         = sd_q;
      mem_we       = 1'b0;
      div_start    = 1'b0;
      div_dividend = '0;
      div_divisor  = '0;
      rem_sh       = {rem_q, rad_q[2*TEMP_WIDTH-1 -: 2]};
      trial        = {1'b0, root_q, 2'b01};
      root_n       = root_q << 1;

      if (sample_w) begin
         tn_d     = TN;
         old_ok_d = full_w;
      end

      case (state_q)
         UPDATE: begin
            sum_d        = sum_q + SUM_W'(tn_q) - SUM_W'(old_w);
            sumsq_d      = sumsq_q + tn_ext * tn_ext - old_ext * old_ext;
            mem_we       = 1'b1;
            wp_d         = (wp_q == PTRW'(N_SAMPLES - 1)) ? '0 : wp_q + 1'b1;
            count_d      = full_w ? count_q : count_q + 1'b1;
            div_start    = 1'b1;
            div_dividend = SQ_W'(sum_d);
            div_divisor  = SQ_W'(count_d);
         end
         DIV_MEAN: begin
            if (div_fin) begin
               mean_d       = TEMP_WIDTH'(div_quo);
               div_start    = 1'b1;
               div_dividend = sumsq_q;
               div_divisor  = SQ_W'(count_q);
            end
         end
         DIV_SQ: begin
            if (div_fin) begin
               qsq_d = div_quo;
            end
         end
         VAR: begin
            rad_d  = (2*TEMP_WIDTH)'(qsq_q - mean_ext * mean_ext);
            rem_d  = '0;
            root_d = '0;
            sqc_d  = '0;
         end
         SQRT: begin
            // One root bit per cycle from the radicand's top bit pair.
            if (rem_sh >= trial) begin
               rem_d  = (TEMP_WIDTH+1)'(rem_sh - trial);
               root_n = (root_q << 1) | TEMP_WIDTH'(1);
            end else begin
               rem_d  = rem_sh[TEMP_WIDTH:0];
            end
            root_d = root_n;
            rad_d  = rad_q << 2;
            sqc_d  = sqc_q + 1'b1;
            if (sqc_q == SCW'(TEMP_WIDTH - 1)) begin
               avg_d = mean_q;
               sd_d  = root_n;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         per_q    <= '0;
         wp_q     <= '0;
         count_q  <= '0;
         sum_q    <= '0;
         sumsq_q  <= '0;
         tn_q     <= '0;
         old_ok_q <= 1'b0;
         mean_q   <= '0;
         qsq_q    <= '0;
         rad_q    <= '0;
         rem_q    <= '0;
         root_q   <= '0;
         sqc_q    <= '0;
         avg_q    <= '0;
         sd_q     <= '0;
      end else begin
         per_q    <= per_d;
         wp_q     <= wp_d;
         count_q  <= count_d;
         sum_q    <= sum_d;
         sumsq_q  <= sumsq_d;
         tn_q     <= tn_d;
         old_ok_q <= old_ok_d;
         mean_q   <= mean_d;
         qsq_q    <= qsq_d;
         rad_q    <= rad_d;
         rem_q    <= rem_d;
         root_q   <= root_d;
         sqc_q    <= sqc_d;
         avg_q    <= avg_d;
         sd_q     <= sd_d;
      end
   end

   // Window storage: clearing count on reset empties it, so the array itself needs no reset.
   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem_q[wp_q] <= tn_q;
      end
      rd_q <= mem_q[wp_q];
   end

   assign SAMPLE = sample_w;
   assign DONE   = (state_q == FIN) && !RESET;
   assign FULL   = full_w;
   assign AVG_SD = (MODE == SD) ? sd_q : avg_q;

endmodule

// File: tb/tb_noaa_stats_engine.sv
// Directed and random checks of noaa_stats_engine against a sliding-window statistics model.
module tb_noaa_stats_engine;

   localparam int TW     = 12;
   localparam int NS     = 14;
   localparam int PERIOD = 128;
   localparam int CW     = $clog2(NS + 1);
   localparam int SQ_W   = 2 * TW + CW;
   localparam int LAT    = 2 * SQ_W + TW + 3;

   logic          CLK   = 1'b0;
   logic          RESET = 1'b1;
   logic          MODE  = 1'b0;
   logic [TW-1:0] TN    = '0;
   logic          SAMPLE;
   logic          DONE;
   logic          FULL;
   logic [TW-1:0] AVG_SD;

   int     passed = 0;
   int     failed = 0;
   int     total  = 0;
   longint cyc    = 0;
   longint last_sample = -1;
   int     hist[$];
   int     exp_avg = 0;
   int     exp_sd  = 0;

   noaa_stats_engine #(
      .TEMP_WIDTH   (TW),
      .N_SAMPLES    (NS),
      .SAMPLE_PERIOD(PERIOD)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .MODE  (MODE),
      .TN    (TN),
      .SAMPLE(SAMPLE),
      .DONE  (DONE),
      .FULL  (FULL),
      .AVG_SD(AVG_SD)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // Window statistics straight from the definition: floor mean, floor mean of squares,
   // their difference as variance, and the largest integer whose square fits under it.
   task automatic model_push(input int v);
      longint s, sq, c, m, q, var_v, r;
      hist.push_back(v);
      if (hist.size() > NS) void'(hist.pop_front());
      s = 0;
      sq = 0;
      foreach (hist[i]) begin
         s  += hist[i];
         sq += longint'(hist[i]) * hist[i];
      end
      c = hist.size();
      m = s / c;
      q = sq / c;
      var_v = q - m * m;
      r = 0;
      while ((r + 1) * (r + 1) <= var_v) r++;
      exp_avg = int'(m);
      exp_sd  = int'(r);
   endtask

   task automatic apply_reset(input int cycles);
      @(negedge CLK);
      RESET = 1'b1;
      repeat (cycles) @(negedge CLK);
      RESET = 1'b0;
      #1;
      hist.delete();
      last_sample = -1;
   endtask

   // Drives v, waits for the strobe, then either follows it to DONE or aborts it with
   // RESET abort_at cycles after the strobe. Returns the cycles waited for the strobe.
   task automatic run_sample(input int v, input int abort_at, output int waited);
      int n;
      int lat;
      int done_seen;
      TN = TW'(v);
      n = 0;
      while (SAMPLE !== 1'b1 && n < 2 * PERIOD) begin
         @(negedge CLK);
         #1;
         n++;
      end
      waited = n;
      check("sample_strobe", SAMPLE, 1);
      if (last_sample >= 0) check("sample_spacing", 32'(cyc - last_sample), PERIOD);
      last_sample = cyc;
      model_push(v);
      @(negedge CLK);
      TN = TW'($urandom_range(4095, 0));
      #1;
      lat = 1;
      if (abort_at > 0) begin
         done_seen = 0;
         while (lat < abort_at) begin
            if (DONE === 1'b1) done_seen++;
            @(negedge CLK);
            #1;
            lat++;
         end
         RESET = 1'b1;
         #1;
         for (int i = 0; i < 20; i++) begin
            if (DONE === 1'b1) done_seen++;
            @(negedge CLK);
            #1;
         end
         check("abort_no_done", done_seen, 0);
         RESET = 1'b0;
         #1;
         hist.delete();
         last_sample = -1;
         $display("sample tn=%0d aborted by reset %0d cycles after strobe", v, abort_at);
      end else begin
         while (DONE !== 1'b1 && lat < LAT + 20) begin
            @(negedge CLK);
            #1;
            lat++;
         end
         check("done_latency", lat, LAT);
         check("sample_done_exclusive", SAMPLE, 0);
         MODE = 1'b0;
         #1;
         check("avg", AVG_SD, exp_avg);
         MODE = 1'b1;
         #1;
         check("sd", AVG_SD, exp_sd);
         check("full", FULL, (hist.size() == NS) ? 1 : 0);
         $display("sample tn=%0d count=%0d avg=%0d sd=%0d full=%0b lat=%0d",
                  v, hist.size(), AVG_SD, exp_sd, FULL, lat);
      end
   endtask

   initial begin
      int w;
      int v;

      repeat (3) @(negedge CLK);
      #1;
      check("rst_sample", SAMPLE, 0);
      check("rst_done", DONE, 0);
      check("rst_full", FULL, 0);
      MODE = 1'b0;
      #1;
      check("rst_avg", AVG_SD, 0);
      MODE = 1'b1;
      #1;
      check("rst_sd", AVG_SD, 0);
      RESET = 1'b0;
      #1;

      // Constant input: the first strobe lands in the first cycle out of reset.
      run_sample(300, 0, w);
      check("first_sample_cycle", w, 0);
      for (int i = 1; i < NS; i++) run_sample(300, 0, w);

      // Partial windows divide by the number of samples actually held.
      apply_reset(2);
      run_sample(500, 0, w);
      check("fill_first_cycle", w, 0);
      apply_reset(2);
      run_sample(100, 0, w);
      run_sample(300, 0, w);

      apply_reset(2);
      for (int i = 0; i < NS; i++) run_sample((i % 2 == 0) ? 100 : 200, 0, w);

      // Fill with zeros, then overwrite every slot with full scale.
      apply_reset(2);
      for (int i = 0; i < NS; i++) run_sample(0, 0, w);
      for (int i = 0; i < NS; i++) run_sample(4095, 0, w);

      for (int i = 0; i < 18; i++) begin
         v = int'($urandom_range(4095, 0));
         run_sample(v, 0, w);
      end

      // Output select follows MODE combinationally and results hold until the next DONE.
      for (int i = 0; i < 30; i++) begin
         @(negedge CLK);
         MODE = ~MODE;
         #1;
         check("mode_toggle", AVG_SD, (MODE == 1'b1) ? exp_sd : exp_avg);
      end

      // Abort inside the square-root phase, then restart from an empty window.
      run_sample(1234, 62, w);
      check("abort_full", FULL, 0);
      MODE = 1'b0;
      #1;
      check("abort_avg", AVG_SD, 0);
      MODE = 1'b1;
      #1;
      check("abort_sd", AVG_SD, 0);
      run_sample(777, 0, w);
      check("restart_sample_cycle", w, 0);
      run_sample(1000, 0, w);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
